// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared definitions for the parameterised matrix multiply core.
//               Holds the FSM state encoding and the result-width helper used
//               by the top level to size the C element width.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    // FSM state encoding (two bits, one spare code that decodes to LOAD)
    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD    = 2'd0;
    localparam state_t ST_COMPUTE = 2'd1;
    localparam state_t ST_OUTPUT  = 2'd2;

    // Width of one C element: a full-precision product plus enough headroom
    // for the N-term dot product to never overflow.
    function automatic int calc_cw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mac
// Description : Single multiply-accumulate lane. Forms a*b at full precision,
//               extends it to CW bits (zero- or sign-extension by SIGNED) and
//               adds it to a running accumulator.
// Ports       : clk, rst_n    - clock, async active-low reset
//               en_i          - accumulate this cycle
//               last_i        - last term of the dot product; accumulator
//                               restarts from zero after this cycle
//               flush_i       - abort; accumulator forced to zero
//               a_i, b_i      - operand elements
//               sum_o         - accumulator plus current product
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mac #(
    parameter int DW     = 8,
    parameter int CW     = 18,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          last_i,
    input  logic          flush_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [CW-1:0] sum_o
);

    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic [CW-1:0] w_prod_ext;

    // Operands are widened to 2*DW before multiplying so the product is
    // computed at full precision in both arithmetic modes.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DW-1:0] w_prod;
            assign w_prod     = $signed({{DW{a_i[DW-1]}}, a_i}) *
                                $signed({{DW{b_i[DW-1]}}, b_i});
            assign w_prod_ext = {{(CW-2*DW){w_prod[2*DW-1]}}, w_prod};
        end else begin : g_unsigned
            logic [2*DW-1:0] w_prod;
            assign w_prod     = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
            assign w_prod_ext = {{(CW-2*DW){1'b0}}, w_prod};
        end
    endgenerate

    assign sum_o = acc_q + w_prod_ext;

    always_comb begin
        acc_d = acc_q;
        if (flush_i) begin
            acc_d = '0;
        end else if (en_i) begin
            // The finished sum leaves through sum_o; start the next element clean
            acc_d = last_i ? '0 : sum_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/param_matmul_core.sv
`default_nettype none
// ============================================================================
// Module      : param_matmul_core
// Description : N x N matrix multiply C = A * B using one shared MAC.
//               LOAD    : 2*N*N stream handshakes fill A then B (row-major)
//               COMPUTE : N^3 cycles, loop order i, j, k (k innermost)
//               OUTPUT  : C streamed row-major with ready/valid backpressure
// Ports       : clk, rst_n            - clock, async active-low reset
//               clear                 - synchronous abort back to LOAD
//               in_data/in_valid/in_ready    - operand input stream
//               out_data/out_valid/out_ready - result output stream
//               out_last              - flags C[N-1][N-1]
//               busy                  - high in COMPUTE and OUTPUT
// Revision    : 1.0 - initial release
// ============================================================================
module param_matmul_core
    import matmul_pkg::*;
#(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    localparam int CW    = calc_cw(DW, N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy
);

    localparam int NN = N * N;
    localparam int LW = $clog2(2 * NN);   // load counter / operand address
    localparam int OW = $clog2(NN);       // result index
    localparam int IW = $clog2(N);        // i, j, k loop counters

    // A occupies entries 0..NN-1 and B entries NN..2*NN-1, so the load
    // counter doubles as the write address.
    logic [DW-1:0] ab_mem [2*NN];
    logic [CW-1:0] c_mem  [NN];

    state_t        state_q,    state_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] k_q, k_d;
    logic [OW-1:0] out_idx_q,  out_idx_d;

    logic          w_in_load;
    logic          w_in_compute;
    logic          w_in_output;
    logic          w_load_hs;
    logic          w_out_hs;
    logic          w_i_last;
    logic          w_j_last;
    logic          w_k_last;
    logic          w_out_idx_last;
    logic [LW-1:0] w_a_addr;
    logic [LW-1:0] w_b_addr;
    logic [OW-1:0] w_c_addr;
    logic [CW-1:0] w_mac_sum;

    assign w_in_load    = (state_q == ST_LOAD);
    assign w_in_compute = (state_q == ST_COMPUTE);
    assign w_in_output  = (state_q == ST_OUTPUT);

    assign w_load_hs = w_in_load && in_valid;
    assign w_out_hs  = w_in_output && out_ready;

    assign w_i_last       = (i_q == IW'(N - 1));
    assign w_j_last       = (j_q == IW'(N - 1));
    assign w_k_last       = (k_q == IW'(N - 1));
    assign w_out_idx_last = (out_idx_q == OW'(NN - 1));

    // A[i][k] and B[k][j] addresses inside the shared operand store
    assign w_a_addr = LW'(i_q) * LW'(N) + LW'(k_q);
    assign w_b_addr = LW'(NN) + LW'(k_q) * LW'(N) + LW'(j_q);
    assign w_c_addr = OW'(i_q) * OW'(N) + OW'(j_q);

    // ------------------------------------------------------------------
    // Next-state and counter logic; clear overrides every handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        out_idx_d  = out_idx_q;

        if (clear) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            out_idx_d  = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (w_load_hs) begin
                        if (load_cnt_q == LW'(2 * NN - 1)) begin
                            load_cnt_d = '0;
                            state_d    = ST_COMPUTE;
                        end else begin
                            load_cnt_d = load_cnt_q + LW'(1);
                        end
                    end
                end

                ST_COMPUTE: begin
                    k_d = k_q + IW'(1);
                    if (w_k_last) begin
                        k_d = '0;
                        j_d = j_q + IW'(1);
                        if (w_j_last) begin
                            j_d = '0;
                            i_d = i_q + IW'(1);
                            if (w_i_last) begin
                                i_d     = '0;
                                state_d = ST_OUTPUT;
                            end
                        end
                    end
                end

                ST_OUTPUT: begin
                    if (w_out_hs) begin
                        if (w_out_idx_last) begin
                            out_idx_d = '0;
                            state_d   = ST_LOAD;
                        end else begin
                            out_idx_d = out_idx_q + OW'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            out_idx_q  <= out_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset, contents are always rewritten by the next job
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_load_hs && !clear) begin
            ab_mem[load_cnt_q] <= in_data;
        end
    end

    // The dot product finishes on the k == N-1 cycle, so the MAC's
    // combinational sum is captured directly into C.
    always_ff @(posedge clk) begin
        if (w_in_compute && w_k_last && !clear) begin
            c_mem[w_c_addr] <= w_mac_sum;
        end
    end

    matmul_mac #(
        .DW     (DW),
        .CW     (CW),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_in_compute && !clear),
        .last_i  (w_k_last),
        .flush_i (clear),
        .a_i     (ab_mem[w_a_addr]),
        .b_i     (ab_mem[w_b_addr]),
        .sum_o   (w_mac_sum)
    );

    // ------------------------------------------------------------------
    // Outputs: decoded from state so they hold naturally under backpressure
    // ------------------------------------------------------------------
    assign in_ready  = w_in_load;
    assign out_valid = w_in_output;
    assign out_last  = w_in_output && w_out_idx_last;
    assign out_data  = w_in_output ? c_mem[out_idx_q] : '0;
    assign busy      = w_in_compute || w_in_output;

endmodule
`default_nettype wire

// File: tb/tb_param_matmul_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_matmul_core
// Description : Directed self-checking bench for param_matmul_core. Three
//               instances: N=3/DW=8 unsigned, N=3/DW=8 signed, N=4/DW=4
//               unsigned. Inputs are driven and outputs sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_matmul_core;

    logic            clk;
    logic            rst_n;
    logic [2:0]      iv;
    logic [2:0]      ordy;
    logic [2:0]      clr;
    logic [2:0][7:0] id;
    wire  [2:0]      ir;
    wire  [2:0]      ov;
    wire  [2:0]      ol;
    wire  [2:0]      bz;
    wire  [17:0]     od0;
    wire  [17:0]     od1;
    wire  [9:0]      od2;

    int n_vec;
    int n_err;

    int av [16];
    int bv [16];
    int ev [16];

    param_matmul_core #(.N(3), .DW(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .clear(clr[0]),
        .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_data(od0), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_last(ol[0]), .busy(bz[0])
    );

    param_matmul_core #(.N(3), .DW(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clr[1]),
        .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_data(od1), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_last(ol[1]), .busy(bz[1])
    );

    param_matmul_core #(.N(4), .DW(4), .SIGNED(0)) u_dut_4 (
        .clk(clk), .rst_n(rst_n), .clear(clr[2]),
        .in_data(id[2][3:0]), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_data(od2), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_last(ol[2]), .busy(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_od(input int d);
        case (d)
            0:       return 32'(od0);
            1:       return 32'(od1);
            default: return 32'(od2);
        endcase
    endfunction

    // Reference product, masked to the result width
    function automatic int sx(input int v, input int dw, input int sgn);
        if (sgn != 0 && v >= (1 << (dw - 1))) return v - (1 << dw);
        return v;
    endfunction

    task automatic ref_mm(input int n, input int dw, input int sgn, input int cw);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < n; k++)
                    s += sx(av[i*n+k], dw, sgn) * sx(bv[k*n+j], dw, sgn);
                ev[i*n+j] = s & ((1 << cw) - 1);
            end
        end
    endtask

    task automatic load_mats(input int d, input int n, input bit gaps);
        for (int e = 0; e < 2*n*n; e++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    iv[d] = 1'b0;
                    @(negedge clk);
                end
            end
            iv[d] = 1'b1;
            id[d] = 8'((e < n*n) ? av[e] : bv[e - n*n]);
            @(negedge clk);
        end
        iv[d] = 1'b0;
        chk("in_ready_low_in_compute", 32'(ir[d]), 32'd0);
        chk("busy_in_compute", 32'(bz[d]), 32'd1);
    endtask

    task automatic finish_job(input int d, input int n, input bit bp);
        int cyc;
        logic [31:0] held;
        cyc = 0;
        while (!ov[d] && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("compute_cycles", 32'(cyc), 32'(n*n*n));
        for (int r = 0; r < n*n; r++) begin
            if (bp) begin
                int s;
                s = $urandom_range(0, 3);
                ordy[d] = 1'b0;
                held = get_od(d);
                for (int t = 0; t < s; t++) begin
                    @(negedge clk);
                    chk("stall_data_hold", get_od(d), held);
                    chk("stall_valid_hold", 32'(ov[d]), 32'd1);
                end
            end
            ordy[d] = 1'b1;
            chk("out_valid", 32'(ov[d]), 32'd1);
            chk("out_data", get_od(d), 32'(ev[r]));
            chk("out_last", 32'(ol[d]), (r == n*n-1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        ordy[d] = 1'b0;
        chk("in_ready_after_job", 32'(ir[d]), 32'd1);
        chk("out_valid_after_job", 32'(ov[d]), 32'd0);
        chk("busy_after_job", 32'(bz[d]), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        clr   = '0;
        id    = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_out_last", 32'(ol[0]), 32'd0);
        chk("rst_out_data", get_od(0), 32'd0);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_out_data_n4", get_od(2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity * (1..9) -> 1..9
        for (int e = 0; e < 9; e++) begin
            av[e] = (e % 4 == 0) ? 1 : 0;
            bv[e] = e + 1;
            ev[e] = e + 1;
        end
        load_mats(0, 3, 1'b0);
        finish_job(0, 3, 1'b0);

        // All 255 unsigned -> 3*255*255 = 195075 everywhere
        for (int e = 0; e < 9; e++) begin
            av[e] = 255;
            bv[e] = 255;
            ev[e] = 195075;
        end
        load_mats(0, 3, 1'b0);
        finish_job(0, 3, 1'b0);

        // Signed: 3 * (-128 * 127) = -48768 -> 18-bit 0x34180
        for (int e = 0; e < 9; e++) begin
            av[e] = 8'h80;
            bv[e] = 127;
            ev[e] = 32'h34180;
        end
        load_mats(1, 3, 1'b0);
        finish_job(1, 3, 1'b0);

        // Identity job again with input gaps and output backpressure
        for (int e = 0; e < 9; e++) begin
            av[e] = (e % 4 == 0) ? 1 : 0;
            bv[e] = e + 1;
            ev[e] = e + 1;
        end
        load_mats(0, 3, 1'b1);
        finish_job(0, 3, 1'b1);

        // clear on the 5th load handshake, then a full job: (1..9) * I
        for (int e = 0; e < 5; e++) begin
            iv[0]  = 1'b1;
            id[0]  = 8'(e + 1);
            clr[0] = (e == 4);
            @(negedge clk);
        end
        iv[0]  = 1'b0;
        clr[0] = 1'b0;
        chk("clear_in_ready", 32'(ir[0]), 32'd1);
        chk("clear_busy", 32'(bz[0]), 32'd0);
        for (int e = 0; e < 9; e++) begin
            av[e] = e + 1;
            bv[e] = (e % 4 == 0) ? 1 : 0;
            ev[e] = e + 1;
        end
        load_mats(0, 3, 1'b0);
        finish_job(0, 3, 1'b0);

        // Async reset mid-COMPUTE, then (1..9)*(1..9)
        for (int e = 0; e < 9; e++) begin
            av[e] = (e % 4 == 0) ? 2 : 0;
            bv[e] = e + 1;
        end
        load_mats(0, 3, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(ir[0]), 32'd1);
        chk("midrst_busy", 32'(bz[0]), 32'd0);
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int e = 0; e < 9; e++) begin
            av[e] = e + 1;
            bv[e] = e + 1;
        end
        ev[0] = 30;  ev[1] = 36;  ev[2] = 42;
        ev[3] = 66;  ev[4] = 81;  ev[5] = 96;
        ev[6] = 102; ev[7] = 126; ev[8] = 150;
        load_mats(0, 3, 1'b0);
        finish_job(0, 3, 1'b0);

        // N=4, DW=4: two back-to-back random jobs
        for (int job = 0; job < 2; job++) begin
            for (int e = 0; e < 16; e++) begin
                av[e] = int'($urandom_range(0, 15));
                bv[e] = int'($urandom_range(0, 15));
            end
            ref_mm(4, 4, 0, 10);
            load_mats(2, 4, 1'b0);
            finish_job(2, 4, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
